microwave_controller: RTL and testbench
=======================================

Name: microwave_controller

Overview:
- Digital microwave-oven controller.
- A one-hot 0–9 keypad enters a cooking time M:ST; start/stop/clear buttons and a door switch control cooking.
- A 1 Hz countdown drives the magnetron enable and three 7-segment digits.
- Top-level FPGA block; keys are assumed already debounced.

Parameters:
- CLK_HZ, 100, clk frequency in Hz; the prescaler produces one countdown tick every CLK_HZ cycles.

Ports:
- clk  in  1  system clock.
- clearn  in  1  synchronous active-low reset; also the user "clear" button.
- kbd  in  10  one-hot keypad, active-high; bit i = digit i.
- startn  in  1  start button, active-low.
- stopn  in  1  stop button, active-low.
- door_closed  in  1  1 = door closed.
- sec_ones_seg  out  7  seconds-ones digit.
- sec_tens_seg  out  7  seconds-tens digit.
- min_segs  out  7  minutes digit.
- mag_on  out  1  magnetron enable.

Behaviour:
- Reset/clear: clearn=0 sampled on a clk edge sets:
  - state=SETUP; digits min=sec_tens=sec_ones=0; prescaler=0; mag_on=0; key/start edge registers cleared.
  - Display shows 0:00.
  - clearn has priority over every other input in the same cycle.
- Segment encoding:
  - Active-low; bit0=a … bit6=g.
  - Digit 0 = 7'b1000000.
  - Codes 10–15 blank (7'h7F).
- Digit registers: three 4-bit BCD values, each 0–9. Seconds-tens may hold up to 9 after entry (e.g. 0:72 is legal).
- Key entry, SETUP state only:
  - Trigger is a rising edge of a valid one-hot kbd: previous sample 0, current sample has exactly one bit set.
  - Shift left: min←sec_tens, sec_tens←sec_ones, sec_ones←digit; the old min is discarded.
  - Entering 1,2,9 gives 1:29.
  - Multi-hot or zero kbd: ignored.
  - Key presses in COOK: ignored.
- Start:
  - Trigger is a falling edge of startn (registered).
  - SETUP→COOK only if door_closed=1, stopn=1 and time≠0:00; otherwise no effect.
  - The prescaler clears on the transition.
- COOK:
  - mag_on=1 combinationally from the state register (mag_on is 1 iff state=COOK).
  - The prescaler counts 0..CLK_HZ-1; at terminal count it wraps and the time decrements once.
  - First decrement occurs CLK_HZ cycles after entering COOK.
- Decrement rule:
  - sec_ones>0: sec_ones−1.
  - sec_ones=0 and sec_tens>0: sec_tens−1, sec_ones=9.
  - Both 0 and min>0: min−1, sec_tens=5, sec_ones=9.
  - Examples: 0:72→0:71…0:60→0:59; 1:00→0:59.
- COOK→SETUP on any of the following; the time is retained in all cases:
  - The decrement yields 0:00; mag_on drops on the same edge that shows 0:00.
  - stopn=0 (level).
  - door_closed=0 (level).
- Resume after stop or door open: a new start press once the door is closed. Closing the door alone does not resume.
- Simultaneous-event priority: clearn > door open / stop > tick decrement > start.
- Two states only: SETUP, COOK; encoding is free.

Optional Feature:
- Macro MICROWAVE_LEAD_BLANK_EN.
- Defined: min_segs is blanked (7'h7F) whenever min=0. When min=0 and sec_tens=0, sec_tens_seg is also blanked. sec_ones is never blanked.
- Undefined: all three digits are always displayed, including zeros.

Decomposition:
- Package microwave_pkg holds:
  - State typedef (SETUP, COOK).
  - BCD digit typedef (4 bits).
  - SEG_BLANK constant.
  - Segment code table for 0–9.
- One natural sub-module: seg7_decoder (4-bit BCD → 7-bit active-low segments), instantiated three times.

Test Plan:
- clearn=0 for 50 cycles → mag_on=0; all digits show 0 (seg 7'h40).
- Keys 1,2, then start pulse, door closed → mag_on=1; display 0:12→0:11 after 100 cycles; 0:00 with mag_on=0 after 1200 cycles.
- Keys 3,5, start, run 5 s, stopn=0 → mag_on=0 and display frozen at 0:30. Then clearn=0 → display 0:00.
- Keys 1,2,9, start, run 3 s (1:26), door_closed=0 → mag_on=0. Close the door → mag_on stays 0. Start → resumes from 1:26.
- Keys 7,2, start → display 0:72 counts to 0:70, then 0:69. Check the 1:00→0:59 borrow separately.
- Start with time 0:00, start with door open, start while stopn=0, and multi-hot kbd → no state change; mag_on stays 0.

Source files
------------

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared types, state constants and 7-segment codes for the microwave controller
package microwave_pkg;

    typedef logic state_t;
    typedef logic [3:0] bcd_t;

    localparam state_t SETUP = 1'b0;
    localparam state_t COOK  = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_CODES [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Digit index of a one-hot keypad word
    function automatic bcd_t key_digit(input logic [9:0] k);
        key_digit = '0;
        for (int i = 0; i < 10; i++)
            if (k[i]) key_digit = bcd_t'(i);
    endfunction

endpackage

// File: rtl/microwave_controller_seg7_decoder.sv
// seg7_decoder: 4-bit BCD to active-low 7-segment pattern, codes 10-15 blank
module seg7_decoder
    import microwave_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = (i_bcd <= 4'd9) ? SEG_CODES[i_bcd] : SEG_BLANK;

endmodule

// File: rtl/microwave_controller.sv
// microwave_controller: keypad time entry, 1 Hz countdown, magnetron enable and 3-digit display
// Optional leading-zero blanking with MICROWAVE_LEAD_BLANK_EN defined.
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int CLK_HZ = 100
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] kbd,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic [6:0] sec_ones_seg,
    output logic [6:0] sec_tens_seg,
    output logic [6:0] min_segs,
    output logic       mag_on
);

    localparam int PW = $clog2(CLK_HZ + 1);

    state_t        r_state;
    bcd_t          r_min, r_tens, r_ones;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_kbd_prev;
    logic          r_start_prev;

    logic w_key, w_start, w_nz, w_tc, w_last;
    bcd_t w_key_dig, w_dmin, w_dtens, w_dones, w_min_dig, w_tens_dig;

    assign w_key     = (r_kbd_prev == '0) && $onehot(kbd);
    assign w_key_dig = key_digit(kbd);
    assign w_start   = ~startn & ~r_start_prev;
    assign w_nz      = {r_min, r_tens, r_ones} != 12'h000;
    assign w_last    = {r_min, r_tens, r_ones} == 12'h001;
    assign w_tc      = r_presc == PW'(CLK_HZ - 1);

    // One-second decrement with BCD borrow; minutes borrow reloads 59
    assign w_dones = (r_ones != 4'd0) ? r_ones - 4'd1 : 4'd9;
    assign w_dtens = (r_ones != 4'd0) ? r_tens : (r_tens != 4'd0) ? r_tens - 4'd1 : 4'd5;
    assign w_dmin  = (r_ones != 4'd0 || r_tens != 4'd0) ? r_min : r_min - 4'd1;

    assign mag_on = r_state == COOK;

    // Mode control, key entry shift register and countdown prescaler
    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_state      <= SETUP;
            r_min        <= '0;
            r_tens       <= '0;
            r_ones       <= '0;
            r_presc      <= '0;
            r_kbd_prev   <= '0;
            r_start_prev <= 1'b0;
        end else begin
            r_kbd_prev   <= kbd;
            r_start_prev <= ~startn;
            if (r_state == SETUP) begin
                if (w_key) begin
                    r_min  <= r_tens;
                    r_tens <= r_ones;
                    r_ones <= w_key_dig;
                end
                if (w_start && door_closed && stopn && w_nz) begin
                    r_state <= COOK;
                    r_presc <= '0;
                end
            end else if (!stopn || !door_closed) begin
                r_state <= SETUP;
            end else if (w_tc) begin
                r_presc <= '0;
                r_min   <= w_dmin;
                r_tens  <= w_dtens;
                r_ones  <= w_dones;
                if (w_last) r_state <= SETUP;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

`ifdef MICROWAVE_LEAD_BLANK_EN
    assign w_min_dig  = (r_min == 4'd0) ? 4'hF : r_min;
    assign w_tens_dig = (r_min == 4'd0 && r_tens == 4'd0) ? 4'hF : r_tens;
`else
    assign w_min_dig  = r_min;
    assign w_tens_dig = r_tens;
`endif

    seg7_decoder u_ones (.i_bcd(r_ones),     .o_seg(sec_ones_seg));
    seg7_decoder u_tens (.i_bcd(w_tens_dig), .o_seg(sec_tens_seg));
    seg7_decoder u_min  (.i_bcd(w_min_dig),  .o_seg(min_segs));

endmodule

// File: tb/tb_microwave_controller.sv
// tb_microwave_controller: directed stimulus with a minutes/seconds reference model checked every cycle
module tb_microwave_controller;

    localparam int HZ = 100;

    logic       clk = 1'b0;
    logic       clearn = 1'b0;
    logic [9:0] kbd = '0;
    logic       startn = 1'b1;
    logic       stopn = 1'b1;
    logic       door_closed = 1'b1;
    logic [6:0] sec_ones_seg, sec_tens_seg, min_segs;
    logic       mag_on;

    int n_vec = 0;
    int n_bad = 0;

    bit         m_cook;
    int         m_min, m_sec, m_cnt;
    logic [9:0] m_pk;
    bit         m_ps;

    microwave_controller #(.CLK_HZ(HZ)) dut (
        .clk(clk), .clearn(clearn), .kbd(kbd), .startn(startn), .stopn(stopn),
        .door_closed(door_closed), .sec_ones_seg(sec_ones_seg),
        .sec_tens_seg(sec_tens_seg), .min_segs(min_segs), .mag_on(mag_on)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'h40; 1: seg = 7'h79; 2: seg = 7'h24; 3: seg = 7'h30; 4: seg = 7'h19;
            5: seg = 7'h12; 6: seg = 7'h02; 7: seg = 7'h78; 8: seg = 7'h00; 9: seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Time kept as minutes plus a 0..99 seconds field; a tick borrows 59 from minutes
    task automatic model_update();
        logic key, st;
        int d;
        if (!clearn) begin
            m_cook = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_pk = '0; m_ps = 1;
        end else begin
            key = (m_pk == '0) && ($countones(kbd) == 1);
            st  = m_ps && !startn;
            d = 0;
            for (int i = 0; i < 10; i++) if (kbd[i]) d = i;
            if (!m_cook) begin
                if (st && door_closed && stopn && (m_min + m_sec) != 0) begin
                    m_cook = 1; m_cnt = 0;
                end
                if (key) begin
                    m_min = m_sec / 10;
                    m_sec = (m_sec % 10) * 10 + d;
                end
            end else if (!stopn || !door_closed) begin
                m_cook = 0;
            end else begin
                m_cnt++;
                if (m_cnt == HZ) begin
                    m_cnt = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_min--; m_sec = 59; end
                    if (m_min == 0 && m_sec == 0) m_cook = 0;
                end
            end
            m_pk = kbd;
            m_ps = startn;
        end
    endtask

    task automatic check_all();
        logic [6:0] e_min, e_tens;
        e_min  = seg(m_min);
        e_tens = seg(m_sec / 10);
`ifdef MICROWAVE_LEAD_BLANK_EN
        if (m_min == 0) e_min = 7'h7F;
        if (m_min == 0 && m_sec / 10 == 0) e_tens = 7'h7F;
`endif
        check("mag_on", {6'b0, mag_on}, {6'b0, m_cook});
        check("min_segs", min_segs, e_min);
        check("sec_tens_seg", sec_tens_seg, e_tens);
        check("sec_ones_seg", sec_ones_seg, seg(m_sec % 10));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic press(input int d);
        kbd = 10'b1 << d; step(2);
        kbd = '0;         step(2);
    endtask

    task automatic start_pulse();
        startn = 1'b0; step(2);
        startn = 1'b1; step(1);
    endtask

    task automatic do_clear();
        clearn = 1'b0; step(2);
        clearn = 1'b1; step(1);
    endtask

    task automatic pin_time(input string name, input logic [6:0] m, input logic [6:0] t,
                            input logic [6:0] o, input logic mg);
        check({name, ".mag"}, {6'b0, mag_on}, {6'b0, mg});
        check({name, ".min"}, min_segs, m);
        check({name, ".tens"}, sec_tens_seg, t);
        check({name, ".ones"}, sec_ones_seg, o);
    endtask

    initial begin
        step(50);
        pin_time("reset", 7'h40, 7'h40, 7'h40, 1'b0);
        clearn = 1'b1; step(2);

        press(1); press(2);
        pin_time("entry12", 7'h40, 7'h79, 7'h24, 1'b0);
        start_pulse();
        pin_time("cook12", 7'h40, 7'h79, 7'h24, 1'b1);
        step(HZ - 3);
        pin_time("pre_tick", 7'h40, 7'h79, 7'h24, 1'b1);
        step(1);
        pin_time("tick011", 7'h40, 7'h79, 7'h79, 1'b1);
        step(11 * HZ - 1);
        pin_time("at001", 7'h40, 7'h40, 7'h79, 1'b1);
        step(1);
        pin_time("done000", 7'h40, 7'h40, 7'h40, 1'b0);
        step(20);

        press(3); press(5);
        start_pulse();
        step(5 * HZ - 2);
        pin_time("run030", 7'h40, 7'h30, 7'h40, 1'b1);
        stopn = 1'b0; step(1);
        pin_time("stop030", 7'h40, 7'h30, 7'h40, 1'b0);
        step(150);
        stopn = 1'b1; step(3);
        pin_time("frozen030", 7'h40, 7'h30, 7'h40, 1'b0);
        do_clear();
        pin_time("clr", 7'h40, 7'h40, 7'h40, 1'b0);

        press(1); press(2); press(9);
        pin_time("entry129", 7'h79, 7'h24, 7'h10, 1'b0);
        start_pulse();
        step(3 * HZ - 2);
        pin_time("run126", 7'h79, 7'h24, 7'h02, 1'b1);
        door_closed = 1'b0; step(1);
        pin_time("door_open", 7'h79, 7'h24, 7'h02, 1'b0);
        step(30);
        door_closed = 1'b1; step(50);
        pin_time("door_shut", 7'h79, 7'h24, 7'h02, 1'b0);
        start_pulse();
        pin_time("resume", 7'h79, 7'h24, 7'h02, 1'b1);
        step(HZ - 3);
        step(1);
        pin_time("run125", 7'h79, 7'h24, 7'h12, 1'b1);
        do_clear();

        press(7); press(2);
        start_pulse();
        step(HZ - 2);
        pin_time("run071", 7'h40, 7'h78, 7'h79, 1'b1);
        step(HZ);
        pin_time("run070", 7'h40, 7'h78, 7'h40, 1'b1);
        step(HZ);
        pin_time("run069", 7'h40, 7'h02, 7'h10, 1'b1);
        do_clear();

        press(1); press(0); press(0);
        pin_time("entry100", 7'h79, 7'h40, 7'h40, 1'b0);
        start_pulse();
        step(HZ - 2);
        pin_time("borrow059", 7'h40, 7'h12, 7'h10, 1'b1);
        do_clear();

        start_pulse();
        pin_time("start_zero", 7'h40, 7'h40, 7'h40, 1'b0);
        press(5);
        door_closed = 1'b0; start_pulse(); door_closed = 1'b1; step(2);
        pin_time("start_door", 7'h40, 7'h40, 7'h12, 1'b0);
        stopn = 1'b0; start_pulse(); stopn = 1'b1; step(2);
        pin_time("start_stop", 7'h40, 7'h40, 7'h12, 1'b0);
        kbd = 10'b0000000110; step(2); kbd = '0; step(2);
        pin_time("multihot", 7'h40, 7'h40, 7'h12, 1'b0);
        start_pulse();
        press(3);
        pin_time("key_in_cook", 7'h40, 7'h40, 7'h12, 1'b1);
        step(HZ);
        clearn = 1'b0; startn = 1'b0; kbd = 10'b0000001000; step(1);
        pin_time("clr_prio", 7'h40, 7'h40, 7'h40, 1'b0);
        clearn = 1'b1; startn = 1'b1; kbd = '0; step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
